// File: rtl/alu_pkg.sv
// Shared constants for the RV64I ALU issue path: ALU op codes, major opcodes,
// funct fields and the funct3 -> base ALU op mapping used by OP and OP-IMM.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_ADDW = 4'hA;
  localparam logic [3:0] ALU_SUBW = 4'hB;
  localparam logic [3:0] ALU_SLLW = 4'hC;
  localparam logic [3:0] ALU_SRLW = 4'hD;
  localparam logic [3:0] ALU_SRAW = 4'hE;
  localparam logic [3:0] ALU_NONE = 4'hF;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  // Base (funct7=0) mapping; shifts and SUB/SRA are refined by the caller.
  function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      F3_ADD:  op = ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV64I decoder: selects ALU operands and op code for one
// instruction; anything the ALU path does not support is flagged illegal.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            wen,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [5:0]      funct6;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt6;
  logic [XLEN-1:0] shamt5;
  logic            unused_rs1_field;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};
  assign unused_rs1_field = ^inst[19:15];

  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] b_raw;
  logic [3:0]      op_raw;
  logic            wen_raw;
  logic            legal;

  always_comb begin
    a_raw   = '0;
    b_raw   = '0;
    op_raw  = ALU_NONE;
    wen_raw = 1'b0;
    legal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_raw   = rs1_data;
        b_raw   = rs2_data;
        wen_raw = 1'b1;
        legal   = 1'b1;
        if (funct7 == F7_BASE)                        op_raw = base_alu_op(funct3);
        else if (funct7 == F7_ALT && funct3 == F3_ADD) op_raw = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == F3_SR)  op_raw = ALU_SRA;
        else                                           legal  = 1'b0;
      end
      OPC_OP_IMM: begin
        a_raw   = rs1_data;
        b_raw   = imm_i;
        wen_raw = 1'b1;
        legal   = 1'b1;
        case (funct3)
          F3_SLL: begin
            b_raw = shamt6;
            if (funct6 == F6_BASE) op_raw = ALU_SLL;
            else                   legal  = 1'b0;
          end
          F3_SR: begin
            b_raw = shamt6;
            if (funct6 == F6_BASE)     op_raw = ALU_SRL;
            else if (funct6 == F6_ALT) op_raw = ALU_SRA;
            else                       legal  = 1'b0;
          end
          default: op_raw = base_alu_op(funct3);
        endcase
      end
      OPC_OP_32: begin
        a_raw   = rs1_data;
        b_raw   = rs2_data;
        wen_raw = 1'b1;
        legal   = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: op_raw = ALU_ADDW;
          {F7_BASE, F3_SLL}: op_raw = ALU_SLLW;
          {F7_BASE, F3_SR}:  op_raw = ALU_SRLW;
          {F7_ALT,  F3_ADD}: op_raw = ALU_SUBW;
          {F7_ALT,  F3_SR}:  op_raw = ALU_SRAW;
          default:           legal  = 1'b0;
        endcase
      end
      OPC_OP_IMM_32: begin
        a_raw   = rs1_data;
        wen_raw = 1'b1;
        legal   = 1'b1;
        // Word shifts only have a 5-bit shamt, so inst[25] must be clear.
        case (funct3)
          F3_ADD: begin
            b_raw  = imm_i;
            op_raw = ALU_ADDW;
          end
          F3_SLL: begin
            b_raw = shamt5;
            if (funct7 == F7_BASE) op_raw = ALU_SLLW;
            else                   legal  = 1'b0;
          end
          F3_SR: begin
            b_raw = shamt5;
            if (funct7 == F7_BASE)     op_raw = ALU_SRLW;
            else if (funct7 == F7_ALT) op_raw = ALU_SRAW;
            else                       legal  = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        b_raw   = imm_u;
        op_raw  = ALU_ADD;
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_AUIPC: begin
        a_raw   = pc;
        b_raw   = imm_u;
        op_raw  = ALU_ADD;
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_LOAD: begin
        a_raw   = rs1_data;
        b_raw   = imm_i;
        op_raw  = ALU_ADD;
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      OPC_STORE: begin
        a_raw  = rs1_data;
        b_raw  = imm_s;
        op_raw = ALU_ADD;
        legal  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        a_raw   = pc;
        b_raw   = XLEN'(4);
        op_raw  = ALU_ADD;
        wen_raw = 1'b1;
        legal   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign rd      = inst[11:7];
  assign alu_op  = legal ? op_raw : ALU_NONE;
  assign a       = legal ? a_raw : '0;
  assign b       = legal ? b_raw : '0;
  assign wen     = legal && wen_raw && (rd != 5'd0);
  assign illegal = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the 64-bit ALU: decodes one instruction per cycle
// into a registered output slot backed by a one-entry skid buffer.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_op;
  logic [4:0]      dec_rd;
  logic            dec_wen;
  logic            dec_illegal;

  alu_ctrl_decode #(.XLEN(XLEN)) u_decode (
    .inst     (in_inst),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .a        (dec_a),
    .b        (dec_b),
    .alu_op   (dec_op),
    .rd       (dec_rd),
    .wen      (dec_wen),
    .illegal  (dec_illegal)
  );

  logic            skid_valid;
  logic [XLEN-1:0] skid_a;
  logic [XLEN-1:0] skid_b;
  logic [3:0]      skid_op;
  logic [4:0]      skid_rd;
  logic            skid_wen;
  logic            skid_illegal;
  logic [XLEN-1:0] skid_pc;

  logic accept;
  logic slot_free;

  // in_ready comes straight from a flop, so upstream sees no comb path from out_ready.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_alu_op   <= ALU_NONE;
      out_rd       <= '0;
      out_wen      <= 1'b0;
      out_illegal  <= 1'b0;
      out_pc       <= '0;
      skid_valid   <= 1'b0;
      skid_a       <= '0;
      skid_b       <= '0;
      skid_op      <= ALU_NONE;
      skid_rd      <= '0;
      skid_wen     <= 1'b0;
      skid_illegal <= 1'b0;
      skid_pc      <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (slot_free) begin
      // A waiting skid entry is older than anything upstream, so it goes first.
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_a       <= skid_a;
        out_b       <= skid_b;
        out_alu_op  <= skid_op;
        out_rd      <= skid_rd;
        out_wen     <= skid_wen;
        out_illegal <= skid_illegal;
        out_pc      <= skid_pc;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_a       <= dec_a;
        out_b       <= dec_b;
        out_alu_op  <= dec_op;
        out_rd      <= dec_rd;
        out_wen     <= dec_wen;
        out_illegal <= dec_illegal;
        out_pc      <= in_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_a       <= dec_a;
      skid_b       <= dec_b;
      skid_op      <= dec_op;
      skid_rd      <= dec_rd;
      skid_wen     <= dec_wen;
      skid_illegal <= dec_illegal;
      skid_pc      <= in_pc;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push expected
// results; a monitor pops and compares on every output handshake.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [63:0] in_rs1_data;
  logic [63:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_illegal;
  logic [63:0] out_pc;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_op  (out_alu_op),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] op, input logic [4:0] rd,
                              input logic wen, input logic ill,
                              input logic [63:0] pc);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd; e.wen = wen; e.ill = ill; e.pc = pc;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [63:0] got,
                              input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Presents one instruction until accepted; expectation is queued at acceptance.
  task automatic apply_stimulus(input logic [31:0] inst, input logic [63:0] pc,
                                input logic [63:0] rs1, input logic [63:0] rs2,
                                input exp_t e);
    bit accepted = 1'b0;
    in_valid    = 1'b1;
    in_inst     = inst;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    for (int c = 0; c < 50 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout: inst %h never accepted, want acceptance within 50 cycles", inst);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: %0d entries still pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_output({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check_output({tag, "_out_a"}, out_a, 64'd0);
    check_output({tag, "_out_b"}, out_b, 64'd0);
    check_output({tag, "_out_pc"}, out_pc, 64'd0);
    check_output({tag, "_out_alu_op"}, 64'(out_alu_op), 64'hF);
    check_output({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    check_output({tag, "_out_wen"}, 64'(out_wen), 64'd0);
    check_output({tag, "_out_illegal"}, 64'(out_illegal), 64'd0);
  endtask

  // Kills held entries while a new instruction is presented in the same cycle.
  task automatic flush_test(input bit fill_skid);
    out_ready = 1'b0;
    apply_stimulus(32'h407302B3, 64'h4000, 64'd3, 64'd1, mk(64'd3, 64'd1, 4'h1, 5'd5, 1'b1, 1'b0, 64'h4000));
    if (fill_skid)
      apply_stimulus(32'h80000137, 64'h4004, 64'd0, 64'd0, mk(64'd0, 64'hFFFF_FFFF_8000_0000, 4'h0, 5'd2, 1'b1, 1'b0, 64'h4004));
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_inst     = 32'hFFF10093;
    in_pc       = 64'h4008;
    in_rs1_data = 64'd9;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check_output(fill_skid ? "flush_full_out_valid" : "flush_half_out_valid", 64'(out_valid), 64'd0);
    check_output(fill_skid ? "flush_full_in_ready" : "flush_half_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output(fill_skid ? "flush_full_no_issue" : "flush_half_no_issue", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed output must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_output: got pc=%h a=%h op=%h, want no output", out_pc, out_a, out_alu_op);
        end else begin
          e = sb.pop_front();
          if (out_a !== e.a || out_b !== e.b || out_alu_op !== e.op || out_rd !== e.rd ||
              out_wen !== e.wen || out_illegal !== e.ill || out_pc !== e.pc) begin
            miscompares++;
            $display("[TB] FAIL issue_pc_%h: got a=%h b=%h op=%h rd=%0d wen=%b ill=%b pc=%h, want a=%h b=%h op=%h rd=%0d wen=%b ill=%b pc=%h",
                     e.pc, out_a, out_b, out_alu_op, out_rd, out_wen, out_illegal, out_pc,
                     e.a, e.b, e.op, e.rd, e.wen, e.ill, e.pc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn        = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    in_inst     = '0;
    in_pc       = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    apply_stimulus(32'hFFF10093, 64'h1000, 64'd5, 64'd0, mk(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 5'd1, 1'b1, 1'b0, 64'h1000));
    @(negedge clk);
    check_output("addi_latency", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    apply_stimulus(32'h407302B3, 64'h1004, 64'h30, 64'h10, mk(64'h30, 64'h10, 4'h1, 5'd5, 1'b1, 1'b0, 64'h1004));
    apply_stimulus(32'h4031D09B, 64'h1008, 64'h123, 64'h77, mk(64'h123, 64'd3, 4'hE, 5'd1, 1'b1, 1'b0, 64'h1008));
    apply_stimulus(32'h80000137, 64'h100C, 64'hAA, 64'd0, mk(64'd0, 64'hFFFF_FFFF_8000_0000, 4'h0, 5'd2, 1'b1, 1'b0, 64'h100C));
    apply_stimulus(32'h023100B3, 64'h1010, 64'd7, 64'd8, mk(64'd0, 64'd0, 4'hF, 5'd1, 1'b0, 1'b1, 64'h1010));
    apply_stimulus(32'h0000007F, 64'h1014, 64'd1, 64'd2, mk(64'd0, 64'd0, 4'hF, 5'd0, 1'b0, 1'b1, 64'h1014));
    apply_stimulus(32'h00001197, 64'h2000, 64'd0, 64'd0, mk(64'h2000, 64'h1000, 4'h0, 5'd3, 1'b1, 1'b0, 64'h2000));
    apply_stimulus(32'hFE512C23, 64'h2004, 64'h100, 64'h55, mk(64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 4'h0, 5'd24, 1'b0, 1'b0, 64'h2004));
    apply_stimulus(32'h000000EF, 64'h3000, 64'd0, 64'd0, mk(64'h3000, 64'd4, 4'h0, 5'd1, 1'b1, 1'b0, 64'h3000));
    apply_stimulus(32'h00208033, 64'h3004, 64'h11, 64'h22, mk(64'h11, 64'h22, 4'h0, 5'd0, 1'b0, 1'b0, 64'h3004));
    apply_stimulus(32'h43F2D213, 64'h3008, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, mk(64'hFFFF_FFFF_FFFF_FFF0, 64'h3F, 4'h9, 5'd4, 1'b1, 1'b0, 64'h3008));
    apply_stimulus(32'h0200909B, 64'h300C, 64'd1, 64'd1, mk(64'd0, 64'd0, 4'hF, 5'd1, 1'b0, 1'b1, 64'h300C));
    apply_stimulus(32'h0083B333, 64'h3010, 64'd5, 64'd6, mk(64'd5, 64'd6, 4'h6, 5'd6, 1'b1, 1'b0, 64'h3010));
    apply_stimulus(32'h40B504BB, 64'h3014, 64'h100, 64'd1, mk(64'h100, 64'd1, 4'hB, 5'd9, 1'b1, 1'b0, 64'h3014));
    apply_stimulus(32'h00000063, 64'h3018, 64'd1, 64'd1, mk(64'd0, 64'd0, 4'hF, 5'd0, 1'b0, 1'b1, 64'h3018));
    apply_stimulus(32'h01043383, 64'h301C, 64'h1000, 64'd0, mk(64'h1000, 64'h10, 4'h0, 5'd7, 1'b1, 1'b0, 64'h301C));
    apply_stimulus(32'h0F00F093, 64'h3020, 64'hABC, 64'd0, mk(64'hABC, 64'hF0, 4'h2, 5'd1, 1'b1, 1'b0, 64'h3020));
    drain();

    // Stall downstream: I0 fills the slot, I1 the skid, I2 must wait.
    out_ready = 1'b0;
    fork
      begin
        apply_stimulus(32'hFFF10093, 64'h100, 64'd1, 64'd0, mk(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 5'd1, 1'b1, 1'b0, 64'h100));
        apply_stimulus(32'h407302B3, 64'h104, 64'd9, 64'd4, mk(64'd9, 64'd4, 4'h1, 5'd5, 1'b1, 1'b0, 64'h104));
        apply_stimulus(32'h80000137, 64'h108, 64'd0, 64'd0, mk(64'd0, 64'hFFFF_FFFF_8000_0000, 4'h0, 5'd2, 1'b1, 1'b0, 64'h108));
      end
      begin
        repeat (3) @(negedge clk);
        check_output("skid_in_ready_low", 64'(in_ready), 64'd0);
        check_output("skid_slot_holds_i0", out_pc, 64'h100);
        repeat (2) @(negedge clk);
        check_output("skid_stall_in_ready", 64'(in_ready), 64'd0);
        check_output("skid_stall_stable_a", out_a, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    flush_test(1'b1);
    flush_test(1'b0);

    // Reset in the middle of a stall drops both held entries.
    out_ready = 1'b0;
    apply_stimulus(32'h407302B3, 64'h5000, 64'd7, 64'd2, mk(64'd7, 64'd2, 4'h1, 5'd5, 1'b1, 1'b0, 64'h5000));
    apply_stimulus(32'h0083B333, 64'h5004, 64'd1, 64'd2, mk(64'd1, 64'd2, 4'h6, 5'd6, 1'b1, 1'b0, 64'h5004));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(32'hFFF10093, 64'h6000, 64'd42, 64'd0, mk(64'd42, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 5'd1, 1'b1, 1'b0, 64'h6000));
    @(negedge clk);
    check_output("post_reset_latency", 64'(out_valid), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute issue stage that sits directly upstream of the 64-bit ALU.
- Takes one fetched/decoded RV64I instruction per cycle with its register-file read data and PC.
- Generates the 4-bit ALU operation code and the selected operand pair (a, b), and holds them in a registered valid/ready pipeline slot with a one-entry skid buffer.
- Output feeds the ALU's a/b/alu_op inputs directly; rd and write-enable travel alongside to writeback.

Parameters:
- XLEN, 64, datapath width of operands and PC.
- (no others)

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  synchronous reset, active-low
- flush  in  1  synchronous kill of all held entries (branch redirect)
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_inst  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- in_rs1_data  in  XLEN  rs1 register value
- in_rs2_data  in  XLEN  rs2 register value
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream accepts
- out_a  out  XLEN  ALU operand a
- out_b  out  XLEN  ALU operand b
- out_alu_op  out  4  ALU op code
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_illegal  out  1  unsupported instruction flag
- out_pc  out  XLEN  PC of issued instruction

Behaviour:
- ALU op encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, ADDW A, SUBW B, SLLW C, SRLW D, SRAW E, NONE F (ALU returns 0).
- OP (0110011):
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: funct3 000 SUB, 101 SRA; anything else illegal.
  - Operands a=rs1, b=rs2.
- OP-IMM (0010011):
  - Same funct3 map; a=rs1, b=sign-extended I-imm.
  - Shifts: b={58'b0, inst[25:20]}. inst[30] selects SRA; inst[31:26] must be 000000 (SLLI/SRLI) or 010000 (SRAI), else illegal.
- OP-32 (0111011): ADDW/SUBW/SLLW/SRLW/SRAW by funct3/funct7; a=rs1, b=rs2; other combinations illegal.
- OP-IMM-32 (0011011):
  - ADDIW uses b=I-imm.
  - SLLIW/SRLIW/SRAIW use b={59'b0, inst[24:20]}; inst[25]=1 is illegal.
- LUI: a=0, b=sign-extended {inst[31:12],12'b0}, ADD.
- AUIPC: a=pc, b=U-imm, ADD.
- LOAD: a=rs1, b=I-imm, ADD, wen=1.
- STORE: a=rs1, b=S-imm, ADD, wen=0.
- JAL/JALR: a=pc, b=4, ADD, wen=1.
- Any other opcode (incl. BRANCH, SYSTEM, M-ext funct7=0000001): op F, a=b=0, wen=0, illegal=1.
- out_rd=inst[11:7]; out_wen forced 0 when rd=0.
- Latency: 1 cycle from in_valid&in_ready to out_valid when the output slot is empty.
- Handshake:
  - Input accepted when in_valid&in_ready. Output consumed when out_valid&out_ready.
  - Output slot holds its payload stable while out_valid&!out_ready.
- Skid:
  - If input is accepted while the output slot is full and not consumed, the decoded entry goes to the skid register and in_ready drops next cycle.
  - On consume, the skid entry moves to the output slot and in_ready rises next cycle.
  - Simultaneous accept+consume with skid empty: new entry loads the output slot directly.
  - Order is strictly preserved.
- Flush: output and skid valid cleared next edge; an input accepted in the flush cycle is discarded. Flush has priority over load.
- Reset (rstn=0 at edge): out_valid=0, skid empty, in_ready=1, out_a/out_b/out_pc=0, out_alu_op=F, out_rd=0, out_wen=0, out_illegal=0. Reset mid-stall drops all entries.

Decomposition:
- Package alu_pkg: ALU op localparams (ADD..NONE), RV opcode constants, funct3/funct7 constants.
- Combinational sub-module alu_ctrl_decode: inst/pc/rs data in, {a,b,alu_op,rd,wen,illegal} out.
- Top level holds the output and skid registers and the handshake logic.

Test Plan:
- ADDI x1,x2,-1 (0xFFF10093), rs1=5 -> next cycle out_valid=1, a=5, b=0xFFFFFFFFFFFFFFFF, op=0, rd=1, wen=1.
- SUB x5,x6,x7 (0x407302B3) -> op=1; SRAIW x1,x3,3 (0x4031D09B) -> op=E, b=3; LUI x2,0x80000 (0x80000137) -> a=0, b=0xFFFFFFFF80000000, op=0.
- MUL x1,x2,x3 (0x023100B3) and an opcode 0x7F word -> op=F, illegal=1, wen=0, a=b=0.
- out_ready=0, push I0,I1,I2 back-to-back -> I0 in the output slot, I1 in skid, in_ready=0 so I2 is held. Raise out_ready -> I0, I1, I2 emerge in order with no loss or duplication.
- Stall with both slots full, assert flush one cycle -> out_valid=0, in_ready=1 next cycle; a concurrently presented input is not issued.
- Assert rstn=0 mid-stream -> next edge all outputs at reset values, in_ready=1; the first post-reset input issues with 1-cycle latency.
